// File: rtl/iob_cpu_bus_arbiter.sv
// iob_cpu_bus_arbiter: shares one iob memory port between ibus and dbus, one outstanding transaction.
// Optional watchdog enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [1:0]          grant,
  output logic                timeout_err
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_D_BURST);
  state_t state, state_n;
  logic [BW-1:0] burst_cnt;
  logic pick_i, pick_d, done, to;
`ifdef IOB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;
  assign to = state != IDLE && !m_ready && to_cnt == TO_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= state == IDLE ? '0 : to_cnt + 1'b1;
      if (to) timeout_err <= 1'b1;
    end
  end
`else
  assign to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    pick_d = d_valid && !(i_valid && burst_cnt == MAXB);
    pick_i = i_valid && !pick_d;
    done = state != IDLE && (m_ready || to) && !rst;
    state_n = state == IDLE ? (pick_d ? GNT_D : pick_i ? GNT_I : IDLE) : done ? IDLE : state;
  end
  assign m_valid = state != IDLE;
  assign grant = {state == GNT_D, state == GNT_I};
  assign i_ready = done && state == GNT_I;
  assign d_ready = done && state == GNT_D;
  assign i_rdata = to ? '0 : m_rdata;
  assign d_rdata = to ? '0 : m_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_addr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (pick_i || pick_d)) begin
        m_addr <= pick_d ? d_addr : i_addr;
        m_wdata <= pick_d ? d_wdata : '0;
        m_wstrb <= pick_d ? d_wstrb : '0;
        burst_cnt <= pick_d && i_valid ? burst_cnt + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// tb_iob_cpu_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level arbitration model.
module tb_iob_cpu_bus_arbiter;
  logic clk = 0, rst = 1;
  logic i_valid = 0, d_valid = 0, m_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_wstrb = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_wstrb;
  logic i_ready, d_ready, m_valid, timeout_err;
  logic [1:0] grant;
  int checks = 0, errors = 0;

  iob_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; i_valid = 0; d_valid = 0; m_ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b exp 0", m_valid); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
    checks++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_payload: got %h %h %h exp 0", m_addr, m_wdata, m_wstrb); end
    checks++; if ({i_ready, d_ready, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {i_ready, d_ready, timeout_err}); end
  endtask

  task automatic test_ibus_fetch();
    do_reset();
    i_valid = 1; i_addr = 32'h100;
    tick();
    checks++; if ({m_valid, grant} !== 3'b101) begin errors++; $display("FAIL fetch_grant: got %b exp 101", {m_valid, grant}); end
    checks++; if ({m_addr, m_wdata, m_wstrb} !== {32'h100, 32'h0, 4'h0}) begin errors++; $display("FAIL fetch_payload: got %h %h %h exp 100 0 0", m_addr, m_wdata, m_wstrb); end
    tick();
    checks++; if ({m_valid, i_ready} !== 2'b10) begin errors++; $display("FAIL fetch_wait: got %b exp 10", {m_valid, i_ready}); end
    tick();
    m_ready = 1; m_rdata = 32'h13;
    #1;
    checks++; if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'h13}) begin errors++; $display("FAIL fetch_resp: got %b%b %h exp 10 13", i_ready, d_ready, i_rdata); end
    tick();
    m_ready = 0; i_valid = 0;
    #1;
    checks++; if ({m_valid, grant, i_ready} !== 4'b0000) begin errors++; $display("FAIL fetch_idle: got %b exp 0000", {m_valid, grant, i_ready}); end
  endtask

  task automatic test_both_rise();
    do_reset();
    i_valid = 1; i_addr = 32'h200; d_valid = 1; d_addr = 32'h3000; d_wstrb = 0;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL both_first: got %b exp 10", grant); end
    m_ready = 1;
    tick();
    m_ready = 0; d_valid = 0;
    tick();
    checks++; if ({grant, m_addr} !== {2'b01, 32'h200}) begin errors++; $display("FAIL both_second: got %b %h exp 01 200", grant, m_addr); end
    m_ready = 1;
    tick();
    m_ready = 0; i_valid = 0;
  endtask

  task automatic test_burst();
    logic [1:0] exp_seq [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    i_valid = 1; d_valid = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (grant !== exp_seq[k]) begin errors++; $display("FAIL burst_%0d: got %b exp %b", k, grant, exp_seq[k]); end
      m_ready = 1;
      tick();
      m_ready = 0;
    end
    i_valid = 0; d_valid = 0;
  endtask

  task automatic test_write_stall();
    int pulses = 0;
    do_reset();
    d_valid = 1; d_addr = 32'h2000; d_wdata = 32'hCAFEBABE; d_wstrb = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h2000, 32'hCAFEBABE, 4'hF}) begin errors++; $display("FAIL stall_%0d: got %b %h %h %h exp 1 2000 cafebabe f", k, m_valid, m_addr, m_wdata, m_wstrb); end
      pulses += int'(d_ready);
      tick();
    end
    m_ready = 1;
    #1;
    pulses += int'(d_ready);
    tick();
    m_ready = 0; d_valid = 0;
    repeat (3) begin pulses += int'(d_ready); tick(); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses: got %0d exp 1", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_valid = 1; i_addr = 32'h44;
    tick();
    rst = 1;
    tick();
    rst = 0; i_valid = 0; m_ready = 1;
    #1;
    checks++; if ({m_valid, grant, i_ready, d_ready} !== 5'b0) begin errors++; $display("FAIL reset_mid: got %b exp 00000", {m_valid, grant, i_ready, d_ready}); end
    tick();
    m_ready = 0;
  endtask

`ifdef IOB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    do_reset();
    d_valid = 1; d_addr = 32'h80; d_wstrb = 0; m_rdata = 32'hDEADBEEF;
    tick();
    repeat (15) begin early += int'(d_ready); tick(); end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d exp 0", early); end
    checks++; if ({d_ready, d_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL timeout_pulse: got %b %h exp 1 0", d_ready, d_rdata); end
    tick();
    d_valid = 0;
    repeat (3) tick();
    checks++; if ({timeout_err, m_valid} !== 2'b10) begin errors++; $display("FAIL timeout_sticky: got %b exp 10", {timeout_err, m_valid}); end
    do_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b exp 0", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    d_valid = 1; d_addr = 32'h80; d_wstrb = 0;
    tick();
    repeat (40) tick();
    checks++; if ({m_valid, d_ready, timeout_err} !== 3'b100) begin errors++; $display("FAIL no_timeout: got %b exp 100", {m_valid, d_ready, timeout_err}); end
    m_ready = 1;
    tick();
    m_ready = 0; d_valid = 0;
  endtask
`endif

  // Transaction-level model: pending flags per master and a streak of dbus wins taken while ibus waited.
  task automatic test_random();
    bit pi = 0, pd = 0, win_d;
    int streak = 0;
    logic [31:0] ia = 0, da = 0, dw = 0, rd;
    logic [3:0] ds = 0;
    do_reset();
    repeat (60) begin
      if (!pi) begin pi = 1'($urandom_range(0, 1)); ia = $urandom; end
      if (!pd) begin pd = 1'($urandom_range(0, 1)); da = $urandom; dw = $urandom; ds = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0; end
      i_valid = pi; i_addr = ia; d_valid = pd; d_addr = da; d_wdata = dw; d_wstrb = ds;
      tick();
      if (!pi && !pd) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_idle: got %b exp 0", m_valid); end
      end else begin
        win_d = pd && !(pi && streak == 4);
        streak = (win_d && pi) ? streak + 1 : 0;
        checks++; if (grant !== (win_d ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_grant: got %b exp %b", grant, win_d ? 2'b10 : 2'b01); end
        checks++; if ({m_addr, m_wdata, m_wstrb} !== (win_d ? {da, dw, ds} : {ia, 32'h0, 4'h0})) begin errors++; $display("FAIL rand_payload: got %h %h %h", m_addr, m_wdata, m_wstrb); end
        repeat ($urandom_range(0, 3)) tick();
        rd = $urandom;
        m_ready = 1; m_rdata = rd;
        #1;
        checks++; if ({i_ready, d_ready} !== {!win_d, win_d}) begin errors++; $display("FAIL rand_ready: got %b%b exp %b%b", i_ready, d_ready, !win_d, win_d); end
        checks++; if ({i_rdata, d_rdata} !== {rd, rd}) begin errors++; $display("FAIL rand_rdata: got %h %h exp %h", i_rdata, d_rdata, rd); end
        tick();
        m_ready = 0;
        if (win_d) pd = 0; else pi = 0;
      end
    end
    i_valid = 0; d_valid = 0;
  endtask

  initial begin
    test_reset();
    test_ibus_fetch();
    test_both_rise();
    test_burst();
    test_write_stall();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
